pipe_stall_ctrl: RTL and testbench

Parametrised hazard and bus-wait controller for the five-stage pipeline: successor to the combinational hazard unit. Adds wait-state handling for the active-low instruction/data bus acknowledges, a bus watchdog and a stall-cycle counter on top of forwarding, load-use stall and branch flush. It sits beside the controller and datapath in the CPU top and drives every stage's stall/flush.

---
 rtl/pipe_stall_ctrl_pkg.sv | 17 +
 rtl/pipe_stall_ctrl_fwd_sel.sv | 25 ++
 rtl/pipe_stall_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline encodings for the hazard / bus-wait controller:
// forward-select codes, the resultSrc load code and the freeze FSM states.
package pipe_stall_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } stall_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_fwd_sel.sv
// Single-operand forwarding select: the M stage result beats the W stage
// result, and register 0 is never forwarded.
module pipe_fwd_sel
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] m_rd,
  input  logic             m_reg_write,
  input  logic [REG_W-1:0] w_rd,
  input  logic             w_reg_write,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (m_reg_write && (m_rd != '0) && (m_rd == rs)) begin
      sel = FWD_M;
    end else if (w_reg_write && (w_rd != '0) && (w_rd == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard and bus-wait controller: forwarding, load-use stall, branch
// flush, bus freeze and stall counter. PIPE_BUS_TIMEOUT_EN adds the bus watchdog.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int WAIT_MAX = 15,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic [REG_W-1:0]  Di_rs1,
  input  logic [REG_W-1:0]  Di_rs2,
  input  logic [REG_W-1:0]  Ei_rs1,
  input  logic [REG_W-1:0]  Ei_rs2,
  input  logic [REG_W-1:0]  Ei_rd,
  input  logic [REG_W-1:0]  Mi_rd,
  input  logic [REG_W-1:0]  Wi_rd,
  input  logic              Di_jal,
  input  logic [1:0]        Ei_prePCSrc,
  input  logic [1:0]        Ei_resultSrc,
  input  logic [1:0]        Mi_resultSrc,
  input  logic              Mi_regWrite,
  input  logic              Wi_regWrite,
  input  logic              Mi_memReq,
  input  logic              ACKI_n,
  input  logic              ACKD_n,
  output logic [1:0]        Eo_forwardIn1Src,
  output logic [1:0]        Eo_forwardIn2Src,
  output logic              Fo_stall,
  output logic              Do_stall,
  output logic              Eo_stall,
  output logic              Mo_stall,
  output logic              Do_flush,
  output logic              Eo_flush,
  output logic              Wo_flush,
  output logic              o_busErr,
  output logic [PERF_W-1:0] o_stallCnt
);

  if (WAIT_MAX < 1) begin : g_bad_wait_max
    $error("pipe_stall_ctrl: WAIT_MAX must be at least 1");
  end

  logic [1:0][REG_W-1:0] e_rs;
  logic [1:0][1:0]       fwd_sel;

  assign e_rs = {Ei_rs2, Ei_rs1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    pipe_fwd_sel #(.REG_W(REG_W)) u_fwd_sel (
      .rs          (e_rs[gi]),
      .m_rd        (Mi_rd),
      .m_reg_write (Mi_regWrite),
      .w_rd        (Wi_rd),
      .w_reg_write (Wi_regWrite),
      .sel         (fwd_sel[gi])
    );
  end

  stall_state_t      state_reg;
  logic [PERF_W-1:0] stall_cnt_reg;
  logic              bus_wait;
  logic              freeze;
  logic              load_use;
  logic              redirect;

  // A data ack only matters while M actually has an access in flight.
  assign bus_wait = ACKI_n | (Mi_memReq & ACKD_n);
  // Freeze is combinational so the cycle that first sees a wait already holds.
  assign freeze   = reset_x & ((state_reg == ST_ERR) | bus_wait);
  assign load_use = (Ei_resultSrc == RES_LOAD) && (Ei_rd != '0) &&
                    ((Ei_rd == Di_rs1) || (Ei_rd == Di_rs2));
  assign redirect = (Ei_prePCSrc != 2'b00);

`ifdef PIPE_BUS_TIMEOUT_EN
  localparam int WCNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  logic [WCNT_W-1:0] wait_cnt_reg;
  logic              bus_err_reg;
  assign o_busErr = bus_err_reg;
`else
  assign o_busErr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_reg <= ST_RUN;
`ifdef PIPE_BUS_TIMEOUT_EN
      wait_cnt_reg <= '0;
      bus_err_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (bus_wait) state_reg <= ST_WAIT;
`ifdef PIPE_BUS_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end
        ST_WAIT: begin
          // An ack arriving on the expiry cycle still wins over the watchdog.
          if (!bus_wait) begin
            state_reg <= ST_RUN;
          end
`ifdef PIPE_BUS_TIMEOUT_EN
          else if (wait_cnt_reg == WCNT_W'(WAIT_MAX - 1)) begin
            state_reg   <= ST_ERR;
            bus_err_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WCNT_W'(1);
          end
`endif
        end
        ST_ERR:  state_reg <= ST_ERR;
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      stall_cnt_reg <= '0;
    end else if (freeze && !(&stall_cnt_reg)) begin
      stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);
    end
  end

  assign o_stallCnt = stall_cnt_reg;

  // Hazard decisions are masked while frozen; E holds, so they re-present later.
  always_comb begin
    Eo_forwardIn1Src = FWD_RF;
    Eo_forwardIn2Src = FWD_RF;
    Fo_stall = 1'b0;
    Do_stall = 1'b0;
    Eo_stall = 1'b0;
    Mo_stall = 1'b0;
    Do_flush = 1'b0;
    Eo_flush = 1'b0;
    Wo_flush = 1'b0;
    if (freeze) begin
      Fo_stall = 1'b1;
      Do_stall = 1'b1;
      Eo_stall = 1'b1;
      Mo_stall = 1'b1;
      Wo_flush = 1'b1;
    end else if (reset_x) begin
      Eo_forwardIn1Src = fwd_sel[0];
      Eo_forwardIn2Src = fwd_sel[1];
      Fo_stall = load_use & ~redirect;
      Do_stall = load_use & ~redirect;
      Do_flush = redirect | Di_jal;
      Eo_flush = redirect | load_use;
    end
  end

  logic unused_ok;
  assign unused_ok = ^Mi_resultSrc;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: stimulus pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares. Honours PIPE_BUS_TIMEOUT_EN.
module tb_pipe_stall_ctrl;

  localparam int REG_W    = 5;
  localparam int WAIT_MAX = 4;
  localparam int PERF_W   = 4;
  localparam int CNT_MAX  = (1 << PERF_W) - 1;

  logic clk = 1'b0;
  logic reset_x;
  logic [REG_W-1:0] Di_rs1, Di_rs2, Ei_rs1, Ei_rs2, Ei_rd, Mi_rd, Wi_rd;
  logic Di_jal;
  logic [1:0] Ei_prePCSrc, Ei_resultSrc, Mi_resultSrc;
  logic Mi_regWrite, Wi_regWrite, Mi_memReq, ACKI_n, ACKD_n;
  logic [1:0] Eo_forwardIn1Src, Eo_forwardIn2Src;
  logic Fo_stall, Do_stall, Eo_stall, Mo_stall, Do_flush, Eo_flush, Wo_flush, o_busErr;
  logic [PERF_W-1:0] o_stallCnt;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.REG_W(REG_W), .WAIT_MAX(WAIT_MAX), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset_x(reset_x),
    .Di_rs1(Di_rs1), .Di_rs2(Di_rs2), .Ei_rs1(Ei_rs1), .Ei_rs2(Ei_rs2),
    .Ei_rd(Ei_rd), .Mi_rd(Mi_rd), .Wi_rd(Wi_rd), .Di_jal(Di_jal),
    .Ei_prePCSrc(Ei_prePCSrc), .Ei_resultSrc(Ei_resultSrc), .Mi_resultSrc(Mi_resultSrc),
    .Mi_regWrite(Mi_regWrite), .Wi_regWrite(Wi_regWrite), .Mi_memReq(Mi_memReq),
    .ACKI_n(ACKI_n), .ACKD_n(ACKD_n),
    .Eo_forwardIn1Src(Eo_forwardIn1Src), .Eo_forwardIn2Src(Eo_forwardIn2Src),
    .Fo_stall(Fo_stall), .Do_stall(Do_stall), .Eo_stall(Eo_stall), .Mo_stall(Mo_stall),
    .Do_flush(Do_flush), .Eo_flush(Eo_flush), .Wo_flush(Wo_flush),
    .o_busErr(o_busErr), .o_stallCnt(o_stallCnt)
  );

  typedef struct packed {
    logic [1:0] f1;
    logic [1:0] f2;
    logic fs, ds, es, ms, df, ef, wf, berr;
    logic [PERF_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int mon_cyc = 0;

  // Reference model state: length of the current unbroken bus-wait run,
  // sticky error flag and frozen-cycle tally.
  int m_run = 0;
  bit m_err = 0;
  int m_cnt = 0;

  function automatic logic [1:0] ref_fwd(input logic [REG_W-1:0] rs);
    if (Mi_regWrite && Mi_rd != 0 && Mi_rd == rs) return 2'b10;
    if (Wi_regWrite && Wi_rd != 0 && Wi_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step();
    exp_t e;
    bit bw, frz, lu, redir;
    e = '0;
    if (!reset_x) begin
      m_run = 0;
      m_err = 0;
      m_cnt = 0;
    end else begin
      bw    = ACKI_n || (Mi_memReq && ACKD_n);
      frz   = m_err || bw;
      lu    = (Ei_resultSrc == 2'b01) && Ei_rd != 0 && (Ei_rd == Di_rs1 || Ei_rd == Di_rs2);
      redir = (Ei_prePCSrc != 0);
      e.cnt  = PERF_W'(m_cnt);
      e.berr = m_err;
      if (frz) begin
        e.fs = 1; e.ds = 1; e.es = 1; e.ms = 1; e.wf = 1;
      end else begin
        e.f1 = ref_fwd(Ei_rs1);
        e.f2 = ref_fwd(Ei_rs2);
        e.fs = lu && !redir;
        e.ds = lu && !redir;
        e.df = redir || Di_jal;
        e.ef = redir || lu;
      end
      if (frz && m_cnt < CNT_MAX) m_cnt++;
      m_run = bw ? m_run + 1 : 0;
`ifdef PIPE_BUS_TIMEOUT_EN
      if (bw && m_run >= WAIT_MAX + 1) m_err = 1;
`endif
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    Di_rs1 = 0; Di_rs2 = 0; Ei_rs1 = 0; Ei_rs2 = 0; Ei_rd = 0; Mi_rd = 0; Wi_rd = 0;
    Di_jal = 0; Ei_prePCSrc = 0; Ei_resultSrc = 0; Mi_resultSrc = 0;
    Mi_regWrite = 0; Wi_regWrite = 0; Mi_memReq = 0; ACKI_n = 0; ACKD_n = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %0h, expected %0h", name, mon_cyc, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd1",   32'(Eo_forwardIn1Src), 32'(e.f1));
        check("fwd2",   32'(Eo_forwardIn2Src), 32'(e.f2));
        check("f_stall", 32'(Fo_stall), 32'(e.fs));
        check("d_stall", 32'(Do_stall), 32'(e.ds));
        check("e_stall", 32'(Eo_stall), 32'(e.es));
        check("m_stall", 32'(Mo_stall), 32'(e.ms));
        check("d_flush", 32'(Do_flush), 32'(e.df));
        check("e_flush", 32'(Eo_flush), 32'(e.ef));
        check("w_flush", 32'(Wo_flush), 32'(e.wf));
        check("bus_err", 32'(o_busErr), 32'(e.berr));
        check("stall_cnt", 32'(o_stallCnt), 32'(e.cnt));
        $display("cyc %0d rst_n=%b ackI=%b ackD=%b req=%b fwd=%b/%b st=%b%b%b%b fl=%b%b%b err=%b cnt=%0d",
                 mon_cyc, reset_x, ACKI_n, ACKD_n, Mi_memReq, Eo_forwardIn1Src, Eo_forwardIn2Src,
                 Fo_stall, Do_stall, Eo_stall, Mo_stall, Do_flush, Eo_flush, Wo_flush,
                 o_busErr, o_stallCnt);
        mon_cyc++;
      end
    end
  end

  initial begin : stimulus
    set_idle();
    reset_x = 1'b0;
    ACKI_n  = 1'b1;
    @(posedge clk);
    #1;
    step();                              // outputs quiet in reset despite a pending ack
    reset_x = 1'b1;
    set_idle();
    step();

    // Forwarding priority: M over W, then W once M's rd is x0.
    Ei_rs1 = 5; Mi_rd = 5; Mi_regWrite = 1; Wi_rd = 5; Wi_regWrite = 1; Ei_rs2 = 5;
    step();
    Mi_rd = 0;
    step();
    set_idle();

    // Load-use on rs2, then a redirect overriding a load-use, then jal.
    Ei_resultSrc = 2'b01; Ei_rd = 7; Di_rs2 = 7;
    step();
    Ei_prePCSrc = 2'b10;
    step();
    set_idle();
    Di_jal = 1;
    step();
    set_idle();

    // Instruction wait of three cycles.
    ACKI_n = 1;
    repeat (3) step();
    ACKI_n = 0;
    step();

    // Overlapping instruction (2) and data (4) waits.
    Mi_memReq = 1; ACKI_n = 1; ACKD_n = 1;
    repeat (2) step();
    ACKI_n = 0;
    repeat (2) step();
    ACKD_n = 0;
    step();
    set_idle();

    // Redirect presented during an instruction wait.
    Ei_prePCSrc = 2'b01; ACKI_n = 1;
    repeat (2) step();
    ACKI_n = 0;
    step();
    set_idle();

    // Data ack stuck high: watchdog (when built in), then reset clears everything.
    Mi_memReq = 1; ACKD_n = 1;
    repeat (8) step();
    reset_x = 1'b0;
    step();
    reset_x = 1'b1;
    set_idle();
    step();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset_x      = ($urandom_range(0, 39) != 0);
      Di_rs1       = REG_W'($urandom_range(0, 3));
      Di_rs2       = REG_W'($urandom_range(0, 3));
      Ei_rs1       = REG_W'($urandom_range(0, 3));
      Ei_rs2       = REG_W'($urandom_range(0, 3));
      Ei_rd        = REG_W'($urandom_range(0, 3));
      Mi_rd        = REG_W'($urandom_range(0, 3));
      Wi_rd        = REG_W'($urandom_range(0, 3));
      Di_jal       = ($urandom_range(0, 7) == 0);
      Ei_prePCSrc  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      Ei_resultSrc = 2'($urandom_range(0, 3));
      Mi_resultSrc = 2'($urandom_range(0, 3));
      Mi_regWrite  = 1'($urandom_range(0, 1));
      Wi_regWrite  = 1'($urandom_range(0, 1));
      Mi_memReq    = 1'($urandom_range(0, 1));
      ACKI_n       = ($urandom_range(0, 3) == 0);
      ACKD_n       = ($urandom_range(0, 2) == 0);
      step();
    end
    reset_x = 1'b1;
    set_idle();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
